// File: rtl/regfile_dump_ctrl_pkg.sv
// regdump_pkg: shared state, record kinds and trace record layout for the run-and-dump controller
package regdump_pkg;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DUMP, DONE} state_t;
  localparam logic KIND_TRACE = 1'b0;
  localparam logic KIND_DUMP = 1'b1;
  localparam int NUM_REGS = 32;
  localparam int TRACE_CYC_W = 10;
  typedef struct packed {
    logic [TRACE_CYC_W-1:0] cycle;
    logic [4:0] rd;
    logic [31:0] data;
  } trace_rec_t;
endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// regfile_dump_ctrl_if: valid/ready record stream towards the debug link
interface regfile_dump_ctrl_if #(parameter int CYC_W = 10);
  logic out_valid;
  logic out_ready;
  logic out_kind;
  logic [CYC_W+4:0] out_tag;
  logic [31:0] out_data;
  modport master (output out_valid, out_kind, out_tag, out_data, input out_ready);
  modport slave (input out_valid, out_kind, out_tag, out_data, output out_ready);
endinterface

// File: rtl/regfile_dump_ctrl_trace_fifo.sv
// trace_fifo: synchronous FIFO; a push into a full FIFO is only accepted alongside a pop
module trace_fifo #(
  parameter int W = 47,
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic we, re;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign re = pop && !empty;
  assign we = push && (!full || re);
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clock)
    if (we) mem[wp[AW-1:0]] <= wdata;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (we) wp <= wp + ONE;
      if (re) rp <= rp + ONE;
    end
endmodule

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: runs the processor for a cycle budget, traces register writes, then dumps r0..r31
module regfile_dump_ctrl
  import regdump_pkg::*;
#(
  parameter int CYC_W = 10,
  parameter int TRACE_DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic [CYC_W-1:0] num_cycles,
  output logic proc_run,
  input  logic rwe,
  input  logic [4:0] rd,
  input  logic [31:0] rData,
  output logic test_mode,
  output logic [4:0] rs1_test,
  input  logic [31:0] regA,
  output logic overflow,
  output logic done,
  regfile_dump_ctrl_if.master stream
);
  localparam int W = CYC_W + 37;
  localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};
  state_t state, nstate;
  logic [CYC_W-1:0] cyc, budget;
  logic [4:0] idx;
  logic dv, go, push, pop, full, empty, tracing, valid;
  logic [31:0] dreg;
  logic [W-1:0] head;
  assign go = start && (state == IDLE || state == DONE);
  assign proc_run = state == RUN;
  assign test_mode = state == DUMP;
  assign done = state == DONE;
  assign tracing = proc_run || state == DRAIN;
  assign rs1_test = test_mode ? idx : '0;
  assign push = proc_run && rwe && rd != 5'd0;
  assign pop = tracing && !empty && stream.out_ready;
  assign valid = test_mode ? dv : tracing && !empty;
  assign stream.out_valid = valid;
  assign stream.out_kind = test_mode ? KIND_DUMP : KIND_TRACE;
  assign stream.out_tag = !valid ? '0 : test_mode ? {{CYC_W{1'b0}}, idx} : head[W-1:32];
  assign stream.out_data = !valid ? '0 : test_mode ? dreg : head[31:0];
  trace_fifo #(.W(W), .DEPTH(TRACE_DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .push(push), .pop(pop),
    .wdata({cyc, rd, rData}), .rdata(head), .full(full), .empty(empty)
  );
  always_comb begin
    nstate = state;
    case (state)
      IDLE, DONE: if (start) nstate = num_cycles == '0 ? DRAIN : RUN;
      RUN: if (cyc == budget - CYC_ONE) nstate = DRAIN;
      DRAIN: if (empty) nstate = DUMP;
      DUMP: if (dv && stream.out_ready && idx == 5'(NUM_REGS - 1)) nstate = DONE;
      default: nstate = IDLE;
    endcase
  end
  // the dump register samples regA one cycle after rs1_test changes, then holds until accepted
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cyc <= '0;
      budget <= '0;
      idx <= '0;
      dv <= 1'b0;
      dreg <= '0;
      overflow <= 1'b0;
    end else begin
      state <= nstate;
      if (go) begin
        budget <= num_cycles;
        cyc <= '0;
        overflow <= 1'b0;
        idx <= '0;
        dv <= 1'b0;
      end
      if (proc_run) cyc <= cyc + CYC_ONE;
      if (push && full && !pop) overflow <= 1'b1;
      if (test_mode) begin
        if (!dv) begin
          dreg <= regA;
          dv <= 1'b1;
        end else if (stream.out_ready) begin
          dv <= 1'b0;
          idx <= idx + 5'd1;
        end
      end
    end
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb_regfile_dump_ctrl: directed and random runs checked against a record-list model of trace and dump output
module tb_regfile_dump_ctrl;
  import regdump_pkg::*;
  localparam int CYC_W = 10;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, rwe = 1'b0;
  logic [CYC_W-1:0] num_cycles = '0;
  logic [4:0] rd = '0;
  logic [31:0] rData = '0;
  logic proc_run, test_mode, overflow, done;
  logic [4:0] rs1_test;
  logic [31:0] regA;
  logic [31:0] rf [32] = '{default: '0};
  regfile_dump_ctrl_if #(.CYC_W(CYC_W)) io ();
  regfile_dump_ctrl #(.CYC_W(CYC_W), .TRACE_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .proc_run(proc_run), .rwe(rwe), .rd(rd), .rData(rData),
    .test_mode(test_mode), .rs1_test(rs1_test), .regA(regA),
    .overflow(overflow), .done(done), .stream(io.master)
  );
  always #5 clock = ~clock;
  always @(posedge clock) if (rwe && rd != 5'd0) rf[rd] <= rData;
  assign regA = rf[rs1_test];

  typedef struct {
    logic kind;
    logic [CYC_W+4:0] tag;
    logic [31:0] data;
  } rec_t;
  rec_t rx[$];
  always @(negedge clock)
    if (reset && io.out_valid && io.out_ready) rx.push_back('{io.out_kind, io.out_tag, io.out_data});

  int cmp = 0, errs = 0, mode = 1;
  trace_rec_t exp_q[$];
  logic [31:0] exp_rf [32];
  bit exp_ovf;
  bit w_en [64];
  logic [4:0] w_rd [64];
  logic [31:0] w_dat [64];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    cmp++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
    io.out_ready = mode == 2 ? 1'($urandom_range(0, 1)) : mode == 1;
  endtask

  task automatic clr();
    for (int k = 0; k < 64; k++) begin
      w_en[k] = 0;
      w_rd[k] = '0;
      w_dat[k] = '0;
    end
  endtask

  task automatic fill_random(int n);
    clr();
    for (int k = 0; k < n; k++) begin
      w_en[k] = 1'($urandom_range(0, 1));
      w_rd[k] = 5'($urandom_range(0, 31));
      w_dat[k] = $urandom;
    end
  endtask

  // Expected output: every nonzero-rd write in order (only the first four survive a stalled run),
  // followed by all 32 registers as they stand after the run.
  task automatic run(int n, bit rdy_run, int hold_idx, int abort_idx);
    int j;
    exp_q.delete();
    exp_ovf = 0;
    rx.delete();
    for (int k = 0; k < n; k++)
      if (w_en[k] && w_rd[k] != 0) begin
        exp_rf[w_rd[k]] = w_dat[k];
        if (!rdy_run && exp_q.size() == 4) exp_ovf = 1;
        else exp_q.push_back('{cycle: TRACE_CYC_W'(k), rd: w_rd[k], data: w_dat[k]});
      end
    mode = rdy_run ? 1 : 0;
    num_cycles = CYC_W'(n);
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < n; k++) begin
      rwe = w_en[k];
      rd = w_rd[k];
      rData = w_dat[k];
      chk("proc_run_high", proc_run, 1);
      step();
    end
    rwe = 0;
    rd = '0;
    rData = '0;
    mode = 2;
    chk("proc_run_low_after_budget", proc_run, 0);
    for (int t = 0; t < 3000 && !done; t++) begin
      if (hold_idx >= 0 && test_mode && io.out_valid && io.out_tag == hold_idx) begin
        io.out_ready = 0;
        for (int h = 0; h < 10; h++) begin
          chk("hold_valid", io.out_valid, 1);
          chk("hold_tag", io.out_tag, hold_idx);
          chk("hold_data", io.out_data, exp_rf[hold_idx]);
          chk("hold_rs1_test", rs1_test, hold_idx);
          @(posedge clock);
          #2;
        end
        hold_idx = -1;
      end
      if (abort_idx >= 0 && test_mode && rs1_test == abort_idx) begin
        #1 reset = 0;
        #1;
        chk("abort_valid", io.out_valid, 0);
        chk("abort_test_mode", test_mode, 0);
        chk("abort_done", done, 0);
        chk("abort_proc_run", proc_run, 0);
        chk("abort_rs1_test", rs1_test, 0);
        #2 reset = 1;
        step();
        return;
      end
      step();
    end
    chk("done_reached", done, 1);
    chk("overflow", overflow, exp_ovf);
    chk("record_count", rx.size(), exp_q.size() + 32);
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
      chk("trace_kind", rx[i].kind, KIND_TRACE);
      chk("trace_tag", rx[i].tag, {exp_q[i].cycle, exp_q[i].rd});
      chk("trace_data", rx[i].data, exp_q[i].data);
    end
    for (int i = 0; i < 32 && exp_q.size() + i < rx.size(); i++) begin
      j = exp_q.size() + i;
      chk("dump_kind", rx[j].kind, KIND_DUMP);
      chk("dump_tag", rx[j].tag, i);
      chk("dump_data", rx[j].data, exp_rf[i]);
    end
    chk("done_valid_low", io.out_valid, 0);
    chk("done_test_mode_low", test_mode, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) exp_rf[i] = '0;
    io.out_ready = 0;
    #1 reset = 0;
    #2;
    chk("rst_proc_run", proc_run, 0);
    chk("rst_test_mode", test_mode, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_valid", io.out_valid, 0);
    chk("rst_kind", io.out_kind, 0);
    chk("rst_tag", io.out_tag, 0);
    chk("rst_data", io.out_data, 0);
    chk("rst_rs1_test", rs1_test, 0);
    @(posedge clock);
    #2 reset = 1;
    clr();
    w_en[1] = 1; w_rd[1] = 5'd1; w_dat[1] = 32'd7;
    w_en[2] = 1; w_rd[2] = 5'd0; w_dat[2] = 32'd9;
    run(5, 1, 3, -1);
    clr();
    run(0, 1, -1, -1);
    clr();
    for (int k = 0; k < 6; k++) begin
      w_en[k] = 1;
      w_rd[k] = 5'(k + 1);
      w_dat[k] = $urandom;
    end
    run(6, 0, -1, -1);
    fill_random(12);
    run(12, 1, -1, 12);
    fill_random(8);
    run(8, 1, -1, -1);
    clr();
    w_en[3] = 1; w_rd[3] = 5'd9; w_dat[3] = $urandom;
    run(4, 1, -1, -1);
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 30);
      fill_random(n);
      run(n, 1'($urandom_range(0, 1)), -1, -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
